// File: rtl/snd_mailbox_pkg.sv
// Shared constants for the sound command mailbox: default data width, empty-read
// value and the FIFO occupancy counter width.
package snd_mailbox_pkg;
  localparam int DW_DEF = 8;
  localparam logic [DW_DEF-1:0] RD_EMPTY = '1;

  // Counter must hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/snd_cmd_fifo.sv
// One mailbox channel: DEPTH-entry FIFO with sticky overflow and a flush that
// overrides any coincident push or pop.
module snd_cmd_fifo
  import snd_mailbox_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4,
  localparam int CW   = cnt_w(DEPTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_pop, do_push;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  // A pop frees the slot this push needs, so a full FIFO still accepts it.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
      if (push & ~do_push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= din;
  end
endmodule

// File: rtl/snd_cmd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: per-channel FIFOs fed by strobe edges,
// a registered read port and a combined active-low interrupt.
module snd_cmd_mailbox
  import snd_mailbox_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4,
  localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    cmd_stb,
  input  logic [NCH*DW-1:0] cmd_data,
  input  logic              rd_req,
  input  logic [SW-1:0]     rd_sel,
  output logic [DW-1:0]     rd_data,
  output logic [NCH-1:0]    busy,
  input  logic [NCH-1:0]    busy_clr,
  input  logic              ext_irq,
  input  logic [NCH:0]      irq_ack,
  output logic              int_n,
  output logic [NCH-1:0]    ovf
);
  logic                    armed;
  logic [NCH-1:0]          stb_q, push_r, full, pop, accept;
  logic [NCH-1:0][DW-1:0]  data_r, head;
  logic [NCH-1:0][CW-1:0]  cnt;
  logic                    ext_q, ext_rise;
  logic [NCH:0]            pend;
  logic [DW-1:0]           sel_head;
  logic                    sel_hit;

  // armed masks the first cycle after reset so levels held high through reset
  // are not mistaken for rising edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed  <= 1'b0;
      stb_q  <= '0;
      push_r <= '0;
      data_r <= '0;
      ext_q  <= 1'b0;
    end else begin
      armed  <= 1'b1;
      stb_q  <= cmd_stb;
      push_r <= cmd_stb & ~stb_q & {NCH{armed}};
      data_r <= cmd_data;
      ext_q  <= ext_irq;
    end
  end

  assign ext_rise = ext_irq & ~ext_q & armed;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    snd_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_r[g]),
      .pop   (pop[g]),
      .clr   (busy_clr[g]),
      .din   (data_r[g]),
      .dout  (head[g]),
      .count (cnt[g]),
      .full  (full[g]),
      .ovf   (ovf[g])
    );
    assign busy[g]   = (cnt[g] != '0);
    assign accept[g] = push_r[g] & ~busy_clr[g] & (~full[g] | pop[g]);
  end

  // Out-of-range selects simply never match, which yields the empty value.
  always_comb begin
    pop      = '0;
    sel_head = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_req && rd_sel == SW'(i) && busy[i]) begin
        pop[i]   = 1'b1;
        sel_head = head[i];
        sel_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_data <= '1;
    else if (rd_req) rd_data <= sel_hit ? sel_head : {DW{1'b1}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      int_n <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (busy_clr[i])    pend[i] <= 1'b0;
        else if (accept[i]) pend[i] <= 1'b1;
        else if (irq_ack[i]) pend[i] <= 1'b0;
      end
      if (ext_rise)          pend[NCH] <= 1'b1;
      else if (irq_ack[NCH]) pend[NCH] <= 1'b0;
      int_n <= ~|pend;
    end
  end
endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed plus random bench for snd_cmd_mailbox against a queue-based model.
module tb_snd_cmd_mailbox;
  import snd_mailbox_pkg::*;
  localparam int NCH = 2, DW = 8, DEPTH = 4;

  logic              clk = 1'b0, rst = 1'b1;
  logic [NCH-1:0]    cmd_stb = '0, busy, busy_clr = '0, ovf;
  logic [NCH*DW-1:0] cmd_data = '0;
  logic              rd_req = 1'b0, ext_irq = 1'b0, int_n;
  logic [0:0]        rd_sel = '0;
  logic [DW-1:0]     rd_data;
  logic [NCH:0]      irq_ack = '0;

  int nchk = 0, nfail = 0;

  // reference model: queues per channel, one-cycle push delay, registered int_n
  logic [7:0]     mq[NCH][$];
  logic [NCH-1:0] m_ovf, m_prev_stb, m_pp;
  logic [7:0]     m_pd[NCH];
  logic [NCH:0]   m_pend;
  logic           m_int_n, m_prev_ext, m_armed;
  logic [7:0]     m_rd;

  snd_cmd_mailbox #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_stb(cmd_stb), .cmd_data(cmd_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy),
    .busy_clr(busy_clr), .ext_irq(ext_irq), .irq_ack(irq_ack),
    .int_n(int_n), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_pd[c] = '0;
    end
    m_ovf = '0; m_prev_stb = '0; m_pp = '0; m_pend = '0;
    m_int_n = 1'b1; m_prev_ext = 1'b0; m_armed = 1'b0; m_rd = RD_EMPTY;
  endtask

  // Apply current inputs for one clock, advance the model, compare, drop pulses.
  task automatic step();
    logic          new_int_n;
    logic [NCH-1:0] eb;
    new_int_n = ~|m_pend;
    if (rd_req) begin
      if (int'(rd_sel) < NCH && mq[rd_sel].size() > 0) m_rd = mq[rd_sel].pop_front();
      else m_rd = RD_EMPTY;
    end
    for (int c = 0; c < NCH; c++) begin
      if (busy_clr[c]) begin
        mq[c].delete(); m_ovf[c] = 1'b0; m_pend[c] = 1'b0;
      end else if (m_pp[c] && mq[c].size() < DEPTH) begin
        mq[c].push_back(m_pd[c]); m_pend[c] = 1'b1;
      end else begin
        if (m_pp[c]) m_ovf[c] = 1'b1;
        if (irq_ack[c]) m_pend[c] = 1'b0;
      end
    end
    if (ext_irq && !m_prev_ext && m_armed) m_pend[NCH] = 1'b1;
    else if (irq_ack[NCH]) m_pend[NCH] = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_pp[c] = cmd_stb[c] & ~m_prev_stb[c] & m_armed;
      m_pd[c] = cmd_data[c*8 +: 8];
    end
    m_prev_stb = cmd_stb; m_prev_ext = ext_irq; m_armed = 1'b1; m_int_n = new_int_n;
    @(posedge clk); #1;
    for (int c = 0; c < NCH; c++) eb[c] = (mq[c].size() != 0);
    chk("m_rd_data", rd_data, m_rd);
    chk("m_busy", busy, eb);
    chk("m_ovf", ovf, m_ovf);
    chk("m_int_n", int_n, m_int_n);
    rd_req = 1'b0; busy_clr = '0; irq_ack = '0;
  endtask

  task automatic push_ch(input int c, input logic [7:0] d);
    cmd_data[c*8 +: 8] = d; cmd_stb[c] = 1'b1; step();
    cmd_stb[c] = 1'b0; step();
  endtask

  task automatic rd(input int c, input logic [7:0] exp, input string tag);
    rd_req = 1'b1; rd_sel = 1'(c); step();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_int_n", int_n, 1);
    #2 rst = 1'b0;
    step();

    // single command round trip
    cmd_data[7:0] = 8'h5A; cmd_stb[0] = 1'b1; step();
    chk("s1_busy_early", busy[0], 0);
    step();
    chk("s1_busy_lat2", busy[0], 1);
    step();
    chk("s1_int_n", int_n, 0);
    rd(0, 8'h5A, "s1_rd");
    chk("s1_busy_after", busy[0], 0);
    cmd_stb[0] = 1'b0; irq_ack = 3'b001; step();

    // overflow on ch1
    for (int k = 1; k <= 5; k++) push_ch(1, 8'(k));
    chk("s2_ovf1", ovf[1], 1);
    for (int k = 1; k <= 4; k++) rd(1, 8'(k), "s2_rd");
    rd(1, 8'hFF, "s2_rd_empty");
    irq_ack = 3'b010; step();

    // push and pop on a full channel
    for (int k = 0; k < 4; k++) push_ch(0, 8'h10 + 8'(k));
    cmd_data[7:0] = 8'h14; cmd_stb[0] = 1'b1; step();
    cmd_stb[0] = 1'b0; rd_req = 1'b1; rd_sel = 1'b0; step();
    chk("s3_rd_oldest", rd_data, 8'h10);
    chk("s3_ovf0", ovf[0], 0);
    for (int k = 1; k <= 4; k++) rd(0, 8'h10 + 8'(k), "s3_rd");
    rd(0, 8'hFF, "s3_rd_empty");
    irq_ack = 3'b001; step();

    // flush beats a coincident push
    for (int k = 0; k < 5; k++) push_ch(0, 8'h20 + 8'(k));
    chk("s4_ovf_pre", ovf[0], 1);
    cmd_data[7:0] = 8'h33; cmd_stb[0] = 1'b1; step();
    cmd_stb[0] = 1'b0; busy_clr = 2'b01; step();
    chk("s4_busy0", busy[0], 0);
    chk("s4_ovf0", ovf[0], 0);
    step();
    chk("s4_int_n", int_n, 1);
    rd(0, 8'hFF, "s4_rd_empty");

    // ext irq set beats a coincident ack
    ext_irq = 1'b1; irq_ack = 3'b100; step();
    step();
    chk("s5_int_n_set", int_n, 0);
    irq_ack = 3'b100; step();
    step();
    chk("s5_int_n_ack", int_n, 1);
    ext_irq = 1'b0; step();

    // async reset mid-operation with a strobe held high
    for (int k = 0; k < 3; k++) push_ch(1, 8'hA1 + 8'(k));
    cmd_stb[0] = 1'b1; step();
    #3 rst = 1'b1;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_ovf", ovf, 0);
    chk("s6_int_n", int_n, 1);
    chk("s6_rd_data", rd_data, 8'hFF);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s6_no_push", busy, 0);
    end
    cmd_stb[0] = 1'b0; step();
    cmd_data[7:0] = 8'h77; cmd_stb[0] = 1'b1; step();
    step();
    chk("s6_fresh_edge", busy[0], 1);
    rd(0, 8'h77, "s6_rd");

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 2) == 0) cmd_stb[c] = ~cmd_stb[c];
        if ($urandom_range(0, 19) == 0) busy_clr[c] = 1'b1;
      end
      cmd_data = NCH*DW'($urandom);
      rd_req   = 1'($urandom);
      rd_sel   = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 3) == 0) irq_ack = 3'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/snd_cmd_mailbox.md
SND_CMD_MAILBOX -- requirements
Module: snd_cmd_mailbox

Interface
REQ-001 The block SHALL use exactly one clock and one reset: clock port clk, reset port rst; rst is asynchronous and active-high.
REQ-002 The block SHALL expose these parameters:
- NCH, 2, command channels (1..4)
- DW, 8, command data width
- DEPTH, 4, FIFO entries per channel (power of 2, >=2)
REQ-003 The block SHALL expose these ports, with clock and reset first:
- clk  in  1  system clock (53.6MHz)
- rst  in  1  asynchronous active-high reset
- cmd_stb  in  NCH  main-CPU command strobe levels; rising edge = push
- cmd_data  in  NCH*DW  command bytes; channel i at [i*DW +: DW]
- rd_req  in  1  one-cycle sound-CPU read pulse (pop)
- rd_sel  in  $clog2(NCH) (min 1)  channel selected for rd_req
- rd_data  out  DW  registered read data
- busy  out  NCH  channel non-empty
- busy_clr  in  NCH  per-channel flush pulse
- ext_irq  in  1  external IRQ level (e.g. OPL irq, active high); rising edge latches
- irq_ack  in  NCH+1  acknowledge pulses: bits [NCH-1:0] for channels, bit NCH for ext
- int_n  out  1  combined active-low interrupt to the sound CPU
- ovf  out  NCH  sticky overflow per channel

Function
REQ-004 The block SHALL register cmd_stb and detect a rising edge as cur & ~prev; a push SHALL occur on the cycle after the edge is seen, capturing cmd_data at the edge cycle.
REQ-005 Each channel SHALL be a DEPTH-entry FIFO with wrapping read/write pointers and a count of width $clog2(DEPTH)+1.
REQ-006 A push to a full channel SHALL be dropped, leave FIFO contents unchanged, and set ovf[i].
REQ-007 On rd_req with rd_sel = i and channel i non-empty, the block SHALL drive rd_data to the head entry in the next cycle and pop it.
REQ-008 On rd_req to an empty channel, or with rd_sel >= NCH, rd_data SHALL become all ones, with no state change.
REQ-009 Without rd_req, rd_data SHALL hold its last value.
REQ-010 A simultaneous push and pop on the same channel SHALL both occur, leaving the count unchanged; this holds when full (push accepted, no ovf) and when empty is not possible for the pop, so an empty channel with simultaneous push/pop SHALL return all ones and accept the push.
REQ-011 busy[i] SHALL equal count_i != 0, taken from registers.
REQ-012 busy_clr[i] SHALL, on the same edge, zero the pointers and count, clear ovf[i] and pend[i], and discard any coincident push (clear wins).
REQ-013 An accepted push SHALL set pend[i]; irq_ack[i] SHALL clear it; when both occur in the same cycle, set SHALL win.
REQ-014 ext_irq SHALL be registered; its rising edge SHALL set pend[NCH]; irq_ack[NCH] SHALL clear it; when both occur in the same cycle, set SHALL win.
REQ-015 int_n SHALL equal ~|pend, driven from registers, one cycle after the pending set.
REQ-016 Push latency from the cmd_stb edge to busy=1 SHALL be 2 clk cycles.

Reset
REQ-017 While rst is high, the block SHALL hold: all pointers and counts 0, busy=0, ovf=0, pend=0, int_n=1, rd_data all ones, and edge-detect registers 0 (a strobe held high through reset SHALL NOT push).
REQ-018 Reset asserted mid-operation SHALL discard all queued commands immediately, with no glitch-free guarantee beyond registered outputs.

Structure
REQ-019 Package snd_mailbox_pkg SHALL hold the DW default, the RD_EMPTY value (all ones), and the count width function.
REQ-020 The per-channel FIFO SHALL be sub-module snd_cmd_fifo (push, pop, clr, din, dout, count, full, ovf), instantiated NCH times by generate; the read mux and IRQ logic SHALL stay at top level.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then cmd_stb[0] 0->1 with data 0x5A -> busy[0]=1 two cycles later; int_n=0; rd_req sel=0 -> rd_data=0x5A next cycle; busy[0]=0.
- Five pushes 0x01..0x05 on ch1 (DEPTH=4) -> ovf[1]=1; four reads return 0x01..0x04; fifth read returns 0xFF.
- Ch0 full, push and pop in the same cycle -> rd_data = oldest entry; count stays 4; ovf[0]=0.
- busy_clr[0] coincident with a push of 0x33 -> busy[0]=0, ovf[0]=0, pend[0]=0; next read returns 0xFF.
- ext_irq rising edge and irq_ack[NCH] in the same cycle -> pend stays 1 (int_n=0); ack alone next cycle -> int_n=1.
- rst asserted with 3 entries queued and cmd_stb held high -> all outputs at reset values; after release, no push until a fresh rising edge.
